// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared state type, widths and divider defaults for the DAC serial writer
//
// Contents:
//   da_state_e   frame sequencer states
//   DA_DATA_W    DAC sample width (bits per frame)
//   DA_SCLK_DIV  default clk_sys cycles per sclk half-period
//   DA_CS_GAP    default minimum cs_n-high time, in sclk periods
//   da_cnt_w()   counter width able to hold values 0..n-1 (never narrower than 1)

package da_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } da_state_e;

  localparam int DA_DATA_W   = 16;
  localparam int DA_SCLK_DIV = 4;
  localparam int DA_CS_GAP   = 2;

  function automatic int da_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/da_sclk_gen.sv
// rtl/da_sclk_gen.sv - half-period divider producing the sclk toggle tick
//
// Ports:
//   clk_sys  in   system clock
//   rst      in   synchronous, active-high reset
//   run      in   count enable; the counter is held at 0 while low
//   restart  in   forces the counter back to 0 (used on sequencer state changes)
//   tick     out  high on the last clk_sys cycle of each half-period
//
// Kept separate from the writer so the ADC capture path can share the same
// divider behaviour.

module da_sclk_gen
  import da_pkg::*;
#(
  parameter int SCLK_DIV = DA_SCLK_DIV
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int            HW     = da_cnt_w(SCLK_DIV);
  localparam logic [HW-1:0] H_LAST = HW'(SCLK_DIV - 1);

  logic [HW-1:0] hcnt;

  // hcnt walks 0..SCLK_DIV-1. A wrap and a restart both land on 0, so a
  // state change on the tick cycle starts the new state with a full
  // half-period.
  always_ff @(posedge clk_sys) begin
    if (rst || !run || restart || (hcnt == H_LAST)) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign tick = run && (hcnt == H_LAST);

endmodule

// File: rtl/da_p2s.sv
// rtl/da_p2s.sv - parallel-to-serial writer for the 16-bit SPI-style DAC
//
// Ports:
//   clk_sys     in   system clock
//   rst         in   synchronous, active-high reset
//   da_data     in   sample to transmit (DATA_W bits), taken on accept only
//   da_vld      in   da_data valid
//   da_rdy      out  block can accept a sample (IDLE only)
//   cs_n        out  DAC chip select, active low
//   sclk        out  DAC serial clock, idles low, DAC samples on rising edge
//   sdin        out  DAC serial data, MSB first
//   busy        out  high from accept until the end of the inter-frame gap
//   frame_done  out  one-cycle pulse on the cycle cs_n returns high
//
// Frame: SETUP (1 half-period, cs_n low, MSB on sdin), SHIFT (2*DATA_W
// half-periods, sclk toggling), HOLD (1 half-period), then GAP
// (2*CS_GAP half-periods with cs_n high) before returning to IDLE.
// All outputs are registered; DATA_W must be at least 2.

module da_p2s
  import da_pkg::*;
#(
  parameter int DATA_W   = DA_DATA_W,
  parameter int SCLK_DIV = DA_SCLK_DIV,
  parameter int CS_GAP   = DA_CS_GAP
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [DATA_W-1:0] da_data,
  input  logic              da_vld,
  output logic              da_rdy,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdin,
  output logic              busy,
  output logic              frame_done
);

  localparam int            BW     = da_cnt_w(DATA_W + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam int            GW     = da_cnt_w(2 * CS_GAP + 1);
  localparam logic [GW-1:0] G_LAST = GW'(2 * CS_GAP - 1);

  da_state_e         state;
  da_state_e         state_d;
  logic              tick;
  logic              accept;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bcnt;   // falling sclk edges seen in this frame
  logic [GW-1:0]     gcnt;   // half-periods elapsed in the gap

  da_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk_sys (clk_sys),
    .rst     (rst),
    .run     (state != IDLE),
    .restart (state_d != state),
    .tick    (tick)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        // da_rdy is registered and only ever high in IDLE.
        if (da_vld && da_rdy) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        // sclk high on a tick means this tick is a falling toggle; the
        // DATA_W-th one closes the shift phase.
        if (tick && sclk && (bcnt == B_LAST)) state_d = HOLD;
      end
      HOLD: begin
        if (tick) state_d = GAP;
      end
      GAP: begin
        if (tick && (gcnt == G_LAST)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they change together with
  // the state register rather than a cycle later.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      da_rdy     <= 1'b0;
      busy       <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      sdin       <= 1'b0;
      frame_done <= 1'b0;
      shift_q    <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
    end else begin
      da_rdy     <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      cs_n       <= !(state_d inside {SETUP, SHIFT, HOLD});
      frame_done <= (state == HOLD) && (state_d == GAP);

      case (state)
        IDLE: begin
          if (accept) begin
            shift_q <= da_data;
            sdin    <= da_data[DATA_W-1];
            sclk    <= 1'b0;
            bcnt    <= '0;
            gcnt    <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              bcnt <= bcnt + 1'b1;
              // The last falling edge leaves the LSB on sdin through HOLD.
              if (bcnt != B_LAST) begin
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                sdin    <= shift_q[DATA_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (tick) sdin <= 1'b0;
        end
        GAP: begin
          if (tick) gcnt <= gcnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
